// File: rtl/axis_int_pkg.sv
// axis_int_pkg: shared constants, FSM state type and source-index helpers for the AXIS tag/data arbiter.
package axis_int_pkg;
    localparam int NUM_SRC = 3;
    localparam logic [1:0] SRC_PE  = 2'd0;
    localparam logic [1:0] SRC_BN  = 2'd1;
    localparam logic [1:0] SRC_RES = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_DATA} state_e;
    function automatic logic [1:0] src_wrap(input logic [1:0] a, input int k);
        int s;
        s = int'(a) + k;
        return 2'(s % NUM_SRC);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from ptr upward modulo NUM_SRC.
module rr_arbiter
    import axis_int_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [1:0]         idx
);
    always_comb begin
        gnt = '0;
        idx = ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[src_wrap(ptr, k)]) begin
                gnt = NUM_SRC'(1) << src_wrap(ptr, k);
                idx = src_wrap(ptr, k);
            end
        end
    end
endmodule

// File: rtl/axis_int_arbiter.sv
// axis_int_arbiter: packet-atomic merge of three (tag, data) AXIS stream pairs into one output pair.
module axis_int_arbiter
    import axis_int_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                s_axis_tlast,
    input  logic [NUM_SRC-1:0]                s_axis_tag_tvalid,
    output logic [NUM_SRC-1:0]                s_axis_tag_tready,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]      s_axis_tag_tdata,
    input  logic [NUM_SRC*TAG_WIDTH/8-1:0]    s_axis_tag_tkeep,
    input  logic [NUM_SRC-1:0]                s_axis_tag_tlast,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [1:0]                        m_axis_tdest,
    input  logic                              m_axis_tag_tready,
    output logic                              m_axis_tag_tvalid,
    output logic [TAG_WIDTH-1:0]              m_axis_tag_tdata,
    output logic [TAG_WIDTH/8-1:0]            m_axis_tag_tkeep,
    output logic                              m_axis_tag_tlast,
    output logic [1:0]                        m_axis_tag_tdest,
    output logic                              busy
);
    localparam int KW  = DATA_WIDTH / 8;
    localparam int TKW = TAG_WIDTH / 8;
    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d, ptr_q, ptr_d, gnt_idx;
    logic [NUM_SRC-1:0] gnt, sel_oh;
    rr_arbiter u_rr (
        .req (s_axis_tag_tvalid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );
    always_comb begin
        sel_oh            = NUM_SRC'(1) << sel_q;
        busy              = state_q != ST_IDLE;
        m_axis_tag_tvalid = (state_q == ST_TAG) && s_axis_tag_tvalid[sel_q];
        m_axis_tag_tdata  = s_axis_tag_tdata[sel_q*TAG_WIDTH +: TAG_WIDTH];
        m_axis_tag_tkeep  = s_axis_tag_tkeep[sel_q*TKW +: TKW];
        m_axis_tag_tlast  = s_axis_tag_tlast[sel_q];
        m_axis_tag_tdest  = sel_q;
        s_axis_tag_tready = (state_q == ST_TAG && m_axis_tag_tready) ? sel_oh : '0;
        m_axis_tvalid     = (state_q == ST_DATA) && s_axis_tvalid[sel_q];
        m_axis_tdata      = s_axis_tdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep      = s_axis_tkeep[sel_q*KW +: KW];
        m_axis_tlast      = s_axis_tlast[sel_q];
        m_axis_tdest      = sel_q;
        s_axis_tready     = (state_q == ST_DATA && m_axis_tready) ? sel_oh : '0;
    end
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (state_q == ST_IDLE && |gnt) begin
            state_d = ST_TAG;
            sel_d   = gnt_idx;
        end
        if (m_axis_tag_tvalid && m_axis_tag_tready) state_d = ST_DATA;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state_d = ST_IDLE;
            ptr_d   = src_wrap(sel_q, 1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_axis_int_arbiter.sv
// tb_axis_int_arbiter: directed and randomized self-checking bench for axis_int_arbiter.
module tb_axis_int_arbiter;
    localparam int DW = 32;
    localparam int TW = 16;
    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [3*DW-1:0] s_axis_tdata;
    logic [11:0]     s_axis_tkeep;
    logic [2:0]      s_axis_tag_tvalid, s_axis_tag_tready, s_axis_tag_tlast;
    logic [3*TW-1:0] s_axis_tag_tdata;
    logic [5:0]      s_axis_tag_tkeep;
    logic            m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [3:0]      m_axis_tkeep;
    logic [1:0]      m_axis_tdest;
    logic            m_axis_tag_tready, m_axis_tag_tvalid, m_axis_tag_tlast;
    logic [TW-1:0]   m_axis_tag_tdata;
    logic [1:0]      m_axis_tag_tkeep;
    logic [1:0]      m_axis_tag_tdest;
    logic            busy;
    int nvec = 0;
    int nerr = 0;
    axis_int_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tag_tvalid(s_axis_tag_tvalid), .s_axis_tag_tready(s_axis_tag_tready),
        .s_axis_tag_tdata(s_axis_tag_tdata), .s_axis_tag_tkeep(s_axis_tag_tkeep),
        .s_axis_tag_tlast(s_axis_tag_tlast),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
        .m_axis_tag_tready(m_axis_tag_tready), .m_axis_tag_tvalid(m_axis_tag_tvalid),
        .m_axis_tag_tdata(m_axis_tag_tdata), .m_axis_tag_tkeep(m_axis_tag_tkeep),
        .m_axis_tag_tlast(m_axis_tag_tlast), .m_axis_tag_tdest(m_axis_tag_tdest),
        .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [TW-1:0] tagv(input int s, input int p);
        return {2'(s), 14'(p)};
    endfunction
    function automatic logic [DW-1:0] datv(input int s, input int p, input int b);
        return {8'(s), 16'(p), 8'(b)};
    endfunction
    function automatic int plen(input int s, input int p);
        return 1 + ((p * 7 + s * 3) % 4);
    endfunction
    function automatic logic [3:0] kexp(input int s);
        return s == 0 ? 4'h3 : s == 1 ? 4'hC : 4'hE;
    endfunction
    function automatic logic [1:0] tkexp(input int s);
        return s == 0 ? 2'b11 : s == 1 ? 2'b01 : 2'b10;
    endfunction
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic apply_reset;
        rst = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tag_tvalid = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b1;
        m_axis_tag_tready = 1'b1;
        step;
        rst = 1'b0;
    endtask
    task automatic xfer(input int s, input int nb, input logic [TW-1:0] tg, input bit keep_tag);
        s_axis_tag_tvalid[s] = 1'b1;
        s_axis_tag_tdata[s*TW +: TW] = tg;
        #1;
        nvec++;
        if ({busy, s_axis_tag_tready, s_axis_tready} !== 7'b0) begin
            nerr++;
            $display("FAIL idle_ready src%0d: busy/tag_rdy/rdy=%b want 0", s, {busy, s_axis_tag_tready, s_axis_tready});
        end
        step;
        nvec++;
        if ({m_axis_tag_tvalid, m_axis_tag_tdest, m_axis_tag_tdata, m_axis_tag_tkeep, m_axis_tag_tlast,
             s_axis_tag_tready, m_axis_tvalid, busy} !== {1'b1, 2'(s), tg, tkexp(s), 1'b1, 3'(1) << s, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL tag_out src%0d: vld=%b dest=%0d data=%h keep=%b rdy=%b mvld=%b want dest=%0d data=%h",
                     s, m_axis_tag_tvalid, m_axis_tag_tdest, m_axis_tag_tdata, m_axis_tag_tkeep,
                     s_axis_tag_tready, m_axis_tvalid, s, tg);
        end
        step;
        if (!keep_tag) s_axis_tag_tvalid[s] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            s_axis_tvalid[s] = 1'b1;
            s_axis_tdata[s*DW +: DW] = datv(s, int'(tg), b);
            s_axis_tlast[s] = (b == nb - 1);
            #1;
            nvec++;
            if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready, m_axis_tag_tvalid}
                !== {1'b1, 2'(s), datv(s, int'(tg), b), kexp(s), b == nb - 1, 3'(1) << s, 1'b0}) begin
                nerr++;
                $display("FAIL data_beat src%0d b%0d: vld=%b dest=%0d data=%h keep=%h last=%b rdy=%b want data=%h",
                         s, b, m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         s_axis_tready, datv(s, int'(tg), b));
            end
            step;
        end
        s_axis_tvalid[s] = 1'b0;
        s_axis_tlast[s] = 1'b0;
        #1;
        nvec++;
        if ({busy, m_axis_tvalid, m_axis_tag_tvalid} !== 3'b0) begin
            nerr++;
            $display("FAIL post_idle src%0d: busy/mvld/mtvld=%b want 000", s, {busy, m_axis_tvalid, m_axis_tag_tvalid});
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        s_axis_tag_tvalid = 3'b111;
        s_axis_tvalid = 3'b111;
        step;
        step;
        nvec++;
        if ({busy, m_axis_tvalid, m_axis_tag_tvalid, s_axis_tready, s_axis_tag_tready} !== 9'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b want 0",
                     {busy, m_axis_tvalid, m_axis_tag_tvalid, s_axis_tready, s_axis_tag_tready});
        end
        apply_reset;
    endtask
    task automatic test_single;
        apply_reset;
        xfer(1, 3, 16'h00A1, 1'b0);
    endtask
    task automatic test_round_robin;
        apply_reset;
        for (int i = 0; i < 3; i++) s_axis_tag_tdata[i*TW +: TW] = 16'h00B0 + 16'(i);
        s_axis_tag_tvalid = 3'b111;
        xfer(0, 2, 16'h00B0, 1'b1);
        xfer(1, 1, 16'h00B1, 1'b1);
        xfer(2, 2, 16'h00B2, 1'b1);
        xfer(0, 1, 16'h00B0, 1'b0);
        s_axis_tag_tvalid = '0;
    endtask
    task automatic test_backpressure;
        int b, cyc;
        bit hs;
        apply_reset;
        s_axis_tag_tvalid[2] = 1'b1;
        s_axis_tag_tdata[2*TW +: TW] = 16'h00C2;
        step;
        step;
        s_axis_tag_tvalid[2] = 1'b0;
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 40) begin
            m_axis_tready = cyc[0] == 1'b0;
            s_axis_tvalid[2] = 1'b1;
            s_axis_tdata[2*DW +: DW] = datv(2, 7, b);
            s_axis_tlast[2] = (b == 3);
            #1;
            nvec++;
            if ({m_axis_tvalid, m_axis_tdest, m_axis_tdata, s_axis_tready}
                !== {1'b1, 2'd2, datv(2, 7, b), m_axis_tready ? 3'b100 : 3'b000}) begin
                nerr++;
                $display("FAIL bp_beat b%0d: vld=%b dest=%0d data=%h rdy=%b want data=%h",
                         b, m_axis_tvalid, m_axis_tdest, m_axis_tdata, s_axis_tready, datv(2, 7, b));
            end
            hs = m_axis_tready;
            step;
            if (hs) b++;
            cyc++;
        end
        s_axis_tvalid[2] = 1'b0;
        s_axis_tlast[2] = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        nvec++;
        if (b != 4 || cyc != 7 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            nerr++;
            $display("FAIL bp_done: beats=%0d cycles=%0d busy=%b want beats=4 cycles=7 busy=0", b, cyc, busy);
        end
    endtask
    task automatic test_data_before_tag;
        apply_reset;
        s_axis_tvalid[0] = 1'b1;
        s_axis_tdata[0 +: DW] = datv(0, 3, 0);
        s_axis_tlast[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++;
            if ({s_axis_tready, busy, m_axis_tvalid} !== 5'b0) begin
                nerr++;
                $display("FAIL early_data_idle: rdy=%b busy=%b mvld=%b want 0", s_axis_tready, busy, m_axis_tvalid);
            end
            step;
        end
        m_axis_tag_tready = 1'b0;
        s_axis_tag_tvalid[0] = 1'b1;
        s_axis_tag_tdata[0 +: TW] = 16'h0035;
        step;
        for (int i = 0; i < 2; i++) begin
            #1;
            nvec++;
            if ({m_axis_tag_tvalid, s_axis_tag_tready, s_axis_tready, m_axis_tvalid} !== 8'b1_000_000_0) begin
                nerr++;
                $display("FAIL tag_stall: mtvld=%b tag_rdy=%b rdy=%b mvld=%b want 1 000 000 0",
                         m_axis_tag_tvalid, s_axis_tag_tready, s_axis_tready, m_axis_tvalid);
            end
            step;
        end
        m_axis_tag_tready = 1'b1;
        #1;
        nvec++;
        if ({s_axis_tag_tready, s_axis_tready} !== 6'b001_000) begin
            nerr++;
            $display("FAIL tag_release: tag_rdy=%b rdy=%b want 001 000", s_axis_tag_tready, s_axis_tready);
        end
        step;
        s_axis_tag_tvalid[0] = 1'b0;
        #1;
        nvec++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata} !== {3'b001, 1'b1, datv(0, 3, 0)}) begin
            nerr++;
            $display("FAIL held_beat: rdy=%b mvld=%b data=%h want 001 1 %h",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, datv(0, 3, 0));
        end
        step;
        s_axis_tvalid[0] = 1'b0;
        s_axis_tlast[0] = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL held_done: busy=%b want 0", busy);
        end
    endtask
    task automatic test_reset_mid;
        apply_reset;
        xfer(1, 1, 16'h0011, 1'b0);
        s_axis_tag_tvalid[0] = 1'b1;
        s_axis_tag_tdata[0 +: TW] = 16'h00E0;
        step;
        step;
        s_axis_tag_tvalid[0] = 1'b0;
        s_axis_tvalid[0] = 1'b1;
        s_axis_tdata[0 +: DW] = datv(0, 9, 0);
        step;
        s_axis_tdata[0 +: DW] = datv(0, 9, 1);
        rst = 1'b1;
        #1;
        nvec++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, datv(0, 9, 1)}) begin
            nerr++;
            $display("FAIL mid_beat2: vld=%b data=%h want 1 %h", m_axis_tvalid, m_axis_tdata, datv(0, 9, 1));
        end
        step;
        nvec++;
        if ({busy, m_axis_tvalid, m_axis_tag_tvalid, s_axis_tready, s_axis_tag_tready} !== 9'b0) begin
            nerr++;
            $display("FAIL mid_rst_outputs: got %b want 0",
                     {busy, m_axis_tvalid, m_axis_tag_tvalid, s_axis_tready, s_axis_tag_tready});
        end
        rst = 1'b0;
        s_axis_tvalid = '0;
        xfer(2, 2, 16'h00D2, 1'b0);
        s_axis_tag_tdata[1*TW +: TW] = 16'h00D1;
        s_axis_tag_tdata[2*TW +: TW] = 16'h00D2;
        s_axis_tag_tvalid = 3'b110;
        step;
        nvec++;
        if (m_axis_tag_tdest !== 2'd1) begin
            nerr++;
            $display("FAIL ptr_after_res: tdest=%0d want 1", m_axis_tag_tdest);
        end
        s_axis_tag_tvalid = '0;
    endtask
    task automatic test_stress;
        int tag_pkt[3], dat_pkt[3], dat_beat[3], exp_tag[3], exp_pkt[3], exp_beat[3], quota[3];
        bit tv[3], dv[3], done;
        logic [2:0] th, dh;
        int cyc, cur;
        apply_reset;
        quota = '{334, 333, 333};
        for (int i = 0; i < 3; i++) begin
            tag_pkt[i] = 0; dat_pkt[i] = 0; dat_beat[i] = 0;
            exp_tag[i] = 0; exp_pkt[i] = 0; exp_beat[i] = 0;
            tv[i] = 1'b0; dv[i] = 1'b0;
        end
        cyc = 0;
        cur = 0;
        done = 1'b0;
        while (!done && cyc < 60000) begin
            for (int i = 0; i < 3; i++) begin
                if (!tv[i] && tag_pkt[i] < quota[i] && $urandom_range(3) != 0) tv[i] = 1'b1;
                if (!dv[i] && dat_pkt[i] < quota[i] && $urandom_range(3) != 0) dv[i] = 1'b1;
                s_axis_tag_tvalid[i] = tv[i];
                s_axis_tag_tdata[i*TW +: TW] = tagv(i, tag_pkt[i]);
                s_axis_tvalid[i] = dv[i];
                s_axis_tdata[i*DW +: DW] = datv(i, dat_pkt[i], dat_beat[i]);
                s_axis_tlast[i] = dat_beat[i] == plen(i, dat_pkt[i]) - 1;
            end
            m_axis_tready = $urandom_range(3) != 0;
            m_axis_tag_tready = $urandom_range(2) != 0;
            #1;
            if (m_axis_tag_tvalid && m_axis_tag_tready) begin
                nvec++;
                cur = int'(m_axis_tag_tdest);
                if (cur > 2 || m_axis_tag_tdata !== tagv(cur, exp_tag[cur]) || exp_pkt[cur] != exp_tag[cur]) begin
                    nerr++;
                    $display("FAIL stress_tag: dest=%0d tag=%h cyc=%0d", cur, m_axis_tag_tdata, cyc);
                    cur = 0;
                end else exp_tag[cur]++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                nvec++;
                if (m_axis_tdest !== 2'(cur) || m_axis_tdata !== datv(cur, exp_pkt[cur], exp_beat[cur]) ||
                    m_axis_tlast !== (exp_beat[cur] == plen(cur, exp_pkt[cur]) - 1) || exp_pkt[cur] + 1 != exp_tag[cur]) begin
                    nerr++;
                    $display("FAIL stress_data: dest=%0d data=%h last=%b want dest=%0d data=%h cyc=%0d",
                             m_axis_tdest, m_axis_tdata, m_axis_tlast, cur, datv(cur, exp_pkt[cur], exp_beat[cur]), cyc);
                end
                if (exp_beat[cur] == plen(cur, exp_pkt[cur]) - 1) begin
                    exp_pkt[cur]++;
                    exp_beat[cur] = 0;
                end else exp_beat[cur]++;
            end
            th = s_axis_tag_tvalid & s_axis_tag_tready;
            dh = s_axis_tvalid & s_axis_tready;
            step;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (th[i]) begin
                    tv[i] = 1'b0;
                    tag_pkt[i]++;
                end
                if (dh[i]) begin
                    dv[i] = 1'b0;
                    if (dat_beat[i] == plen(i, dat_pkt[i]) - 1) begin
                        dat_pkt[i]++;
                        dat_beat[i] = 0;
                    end else dat_beat[i]++;
                end
            end
            done = exp_pkt[0] >= quota[0] && exp_pkt[1] >= quota[1] && exp_pkt[2] >= quota[2];
        end
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL stress_timeout: pkts=%0d/%0d/%0d after %0d cycles", exp_pkt[0], exp_pkt[1], exp_pkt[2], cyc);
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (exp_tag[i] != quota[i] || exp_pkt[i] != quota[i]) begin
                nerr++;
                $display("FAIL stress_count src%0d: tags=%0d pkts=%0d want %0d", i, exp_tag[i], exp_pkt[i], quota[i]);
            end
        end
        s_axis_tvalid = '0;
        s_axis_tag_tvalid = '0;
    endtask
    initial begin
        rst = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tkeep = {4'hE, 4'hC, 4'h3};
        s_axis_tlast = '0;
        s_axis_tag_tvalid = '0;
        s_axis_tag_tdata = '0;
        s_axis_tag_tkeep = {2'b10, 2'b01, 2'b11};
        s_axis_tag_tlast = 3'b111;
        m_axis_tready = 1'b1;
        m_axis_tag_tready = 1'b1;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_data_before_tag;
        test_reset_mid;
        test_stress;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
